stream_mux_rr: RTL and testbench

Parametrised N-channel, W-bit streaming multiplexer. It is the clocked successor to the team's gated 2:1 mux.
- Selects one input channel per packet, by round-robin arbitration or by a fixed select input.
- Forwards beats with a valid/ready handshake through a single output register.
- Sits between multiple packet sources and one shared downstream consumer.

---
 rtl/stream_mux_rr.sv | 183 ++++++++++++++++++
 tb/tb_stream_mux_rr.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N-channel packet stream mux with round-robin or fixed-select arbitration and a registered output.
// Define STREAM_MUX_WATCHDOG_EN to abandon packets whose granted source stalls for TIMEOUT cycles.
module stream_mux_rr #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned CW      = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MODE,
  input  logic [CW-1:0]     SEL,
  input  logic [N_CH*W-1:0] IN_DATA,
  input  logic [N_CH-1:0]   IN_VALID,
  input  logic [N_CH-1:0]   IN_LAST,
  output logic [N_CH-1:0]   IN_READY,
  output logic [W-1:0]      OUT_DATA,
  output logic              OUT_VALID,
  output logic              OUT_LAST,
  output logic [CW-1:0]     OUT_CHAN,
  input  logic              OUT_READY,
  output logic              ERR_TIMEOUT
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam int unsigned CW1 = CW + 1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] grant_q, grant_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] ptr_next;

  logic [W-1:0]  data_q;
  logic          valid_q, last_q;
  logic [CW-1:0] chan_q;

  logic          load_en, xfer, timeout;
  logic          g_valid, g_last;
  logic [W-1:0]  g_data;

  logic            cand_found;
  logic [CW-1:0]   cand, off;
  logic [CW1-1:0]  sum;
  logic [2*N_CH-1:0] dbl;

  assign load_en  = !valid_q || OUT_READY;
  assign xfer     = (state_q == BUSY) && g_valid && load_en;
  assign ptr_next = (grant_q == CW'(N_CH - 1)) ? '0 : grant_q + CW'(1);

  // Granted-channel view of the input bundle
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant_q == CW'(i)) begin
        g_valid = IN_VALID[i];
        g_last  = IN_LAST[i];
        g_data  = IN_DATA[i*W +: W];
      end
    end
  end

  // Candidate search: rotate valids so PTR lands on bit 0, take the lowest set bit
  always_comb begin
    cand_found = 1'b0;
    cand       = '0;
    off        = '0;
    sum        = '0;
    dbl        = {IN_VALID, IN_VALID} >> ptr_q;
    if (MODE) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (SEL == CW'(i) && IN_VALID[i]) begin
          cand_found = 1'b1;
          cand       = CW'(i);
        end
      end
    end else begin
      for (int unsigned j = 0; j < N_CH; j++) begin
        if (!cand_found && dbl[j]) begin
          cand_found = 1'b1;
          off        = CW'(j);
        end
      end
      sum = {1'b0, ptr_q} + CW1'(off);
      if (sum >= CW1'(N_CH)) begin
        sum = sum - CW1'(N_CH);
      end
      cand = sum[CW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (cand_found) begin
          grant_d = cand;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if ((xfer && g_last) || timeout) begin
          state_d = IDLE;
          ptr_d   = ptr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    IN_READY = '0;
    if (state_q == BUSY && load_en && !RST) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (grant_q == CW'(i)) begin
          IN_READY[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      chan_q  <= '0;
    end else if (xfer) begin
      data_q  <= g_data;
      valid_q <= 1'b1;
      last_q  <= g_last;
      chan_q  <= grant_q;
    end else if (load_en) begin
      valid_q <= 1'b0;
    end
  end

  assign OUT_DATA  = data_q;
  assign OUT_VALID = valid_q;
  assign OUT_LAST  = last_q;
  assign OUT_CHAN  = chan_q;

`ifdef STREAM_MUX_WATCHDOG_EN
  localparam int unsigned SW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] stall_q;

  // Counts cycles the granted source has nothing to offer; a stalled-but-valid beat just holds
  assign timeout = (state_q == BUSY) && !g_valid && (stall_q == SW'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_q <= '0;
    end else if (state_q == IDLE || xfer || timeout) begin
      stall_q <= '0;
    end else if (!g_valid) begin
      stall_q <= stall_q + SW'(1);
    end
  end

  assign ERR_TIMEOUT = timeout;
`else
  assign timeout     = 1'b0;
  assign ERR_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: packet-level arbitration model feeds an expected-beat queue.
module tb_stream_mux_rr;

  localparam int N_CH    = 3;
  localparam int W       = 8;
  localparam int CW      = 2;
  localparam int TIMEOUT = 16;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              MODE = 1'b0;
  logic [CW-1:0]     SEL = '0;
  logic [N_CH*W-1:0] IN_DATA = '0;
  logic [N_CH-1:0]   IN_VALID = '0;
  logic [N_CH-1:0]   IN_LAST = '0;
  logic [N_CH-1:0]   IN_READY;
  logic [W-1:0]      OUT_DATA;
  logic              OUT_VALID;
  logic              OUT_LAST;
  logic [CW-1:0]     OUT_CHAN;
  logic              OUT_READY = 1'b0;
  logic              ERR_TIMEOUT;

  stream_mux_rr #(
    .N_CH(N_CH), .W(W), .CW(CW), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST(RST), .MODE(MODE), .SEL(SEL),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_LAST(OUT_LAST), .OUT_CHAN(OUT_CHAN),
    .OUT_READY(OUT_READY), .ERR_TIMEOUT(ERR_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {logic [W-1:0] data; logic last;} beat_t;
  typedef struct packed {logic [W-1:0] data; logic last; logic [CW-1:0] chan;} exp_t;

  beat_t src_q[N_CH][$];   // what each source still has to send
  beat_t pend[N_CH][$];    // same packets as seen by the model, not yet scheduled
  exp_t  exp_q[$];

  logic [N_CH-1:0] acc = '0, mid_pkt = '0, hold = '0;
  bit gap_en = 0, rdy_rand = 0;
  int checks = 0, errors = 0;
  int ptr_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Sources: hold VALID whenever a beat is queued, except for random gaps inside a packet
  task automatic drive();
    beat_t b;
    for (int i = 0; i < N_CH; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        IN_VALID[i] = !(mid_pkt[i] && (hold[i] || (gap_en && $urandom_range(3) == 0)));
        IN_DATA[i*W +: W] = b.data;
        IN_LAST[i] = b.last;
      end else begin
        IN_VALID[i] = 1'b0;
        IN_DATA[i*W +: W] = W'($urandom);
        IN_LAST[i] = 1'b0;
      end
    end
    if (rdy_rand) OUT_READY = ($urandom_range(3) != 0);
  endtask

  initial begin
    beat_t b;
    forever begin
      @(negedge CLK);
      acc = IN_VALID & IN_READY;
      @(posedge CLK);
      #1;
      for (int i = 0; i < N_CH; i++) begin
        if (acc[i] && src_q[i].size() > 0) begin
          b = src_q[i].pop_front();
          mid_pkt[i] = !b.last;
        end
      end
      drive();
    end
  end

  // Monitor: every output handshake must match the head of the expected queue
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h chan %0d expected none", OUT_DATA, OUT_CHAN);
        end else begin
          e = exp_q.pop_front();
          check("out_data", OUT_DATA, e.data);
          check("out_last", OUT_LAST, e.last);
          check("out_chan", OUT_CHAN, e.chan);
        end
      end
    end
  end

  task automatic load_pkt(input int ch, input int len, input logic [W-1:0] base, input bit rnd);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = rnd ? W'($urandom) : base + W'(k);
      b.last = (k == len - 1);
      src_q[ch].push_back(b);
      pend[ch].push_back(b);
    end
  endtask

  // Model: one whole packet from channel c goes out next; pointer moves past c
  task automatic model_take(input int c);
    beat_t b;
    exp_t e;
    do begin
      b = pend[c].pop_front();
      e.data = b.data;
      e.last = b.last;
      e.chan = CW'(c);
      exp_q.push_back(e);
    end while (!b.last);
    ptr_m = (c + 1) % N_CH;
  endtask

  // Round robin over channels that have packets waiting
  task automatic model_rr();
    int c;
    bit found;
    forever begin
      found = 0;
      c = 0;
      for (int k = 0; k < N_CH; k++) begin
        if (!found && pend[(ptr_m + k) % N_CH].size() > 0) begin
          found = 1;
          c = (ptr_m + k) % N_CH;
        end
      end
      if (!found) break;
      model_take(c);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic wait_out_valid(input string name);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!OUT_VALID && n < 50);
    check(name, OUT_VALID, 1);
  endtask

  initial begin
    int n, first, last, vcnt, bad, c;
    beat_t b;
    exp_t e;

    // Reset values
    repeat (3) @(posedge CLK);
    #2;
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_out_data", OUT_DATA, 0);
    check("rst_out_chan", OUT_CHAN, 0);
    check("rst_in_ready", IN_READY, 0);
    RST = 1'b0;
    tick();

    // Latency: IN_VALID at cycle 0, IN_READY at 1, OUT_VALID at 2
    OUT_READY = 1'b1;
    load_pkt(1, 1, 8'h3C, 0);
    model_take(1);
    tick();
    @(negedge CLK);
    check("lat_c0_ready", IN_READY, 0);
    check("lat_c0_valid", OUT_VALID, 0);
    tick();
    @(negedge CLK);
    check("lat_c1_ready", IN_READY, 3'b010);
    tick();
    @(negedge CLK);
    check("lat_c2_valid", OUT_VALID, 1);
    drain("lat_drain");

    // Fairness: all channels offer two 2-beat packets, no backpressure
    for (int ch = 0; ch < N_CH; ch++) begin
      load_pkt(ch, 2, W'(16 * ch + 16), 0);
      load_pkt(ch, 2, W'(16 * ch + 24), 0);
    end
    model_rr();
    first = -1; last = 0; vcnt = 0; n = 0;
    while (vcnt < 12 && n < 200) begin
      @(negedge CLK);
      if (OUT_VALID) begin
        if (first < 0) first = n;
        last = n;
        vcnt++;
      end
      n++;
    end
    check("rr_beats", vcnt, 12);
    check("rr_span_one_gap", last - first + 1, 17);
    drain("rr_drain");

    // Random traffic, source gaps and downstream backpressure
    gap_en = 1;
    rdy_rand = 1;
    for (int r = 0; r < 2; r++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        n = $urandom_range(3);
        for (int p = 0; p < n; p++) load_pkt(ch, $urandom_range(1, 4), '0, 1);
      end
      model_rr();
      drain("rand_drain");
    end
    gap_en = 0;
    rdy_rand = 0;
    tick();
    OUT_READY = 1'b1;

    // Fixed select: only ch2 until its packet ends, then SEL=0 takes effect
    MODE = 1'b1;
    SEL = 2'd2;
    load_pkt(0, 2, 8'hC0, 0);
    load_pkt(2, 2, 8'hA0, 0);
    load_pkt(2, 4, 8'hB0, 0);
    model_take(2);
    model_take(2);
    model_take(0);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(OUT_VALID && OUT_DATA == 8'hB0) && n < 100);
    check("fix_b0_seen", OUT_DATA, 8'hB0);
    tick();
    SEL = 2'd0;
    drain("fix_drain");

    // Out-of-range SEL never grants
    SEL = 2'd3;
    for (int ch = 0; ch < N_CH; ch++) load_pkt(ch, 2, '0, 1);
    bad = 0;
    repeat (12) begin
      @(negedge CLK);
      if (IN_READY != 0 || OUT_VALID) bad++;
    end
    check("sel_oob_idle", bad, 0);
    tick();
    MODE = 1'b0;
    model_rr();
    drain("sel_oob_drain");

    // Backpressure holds the output and blocks IN_READY
    c = ptr_m;
    OUT_READY = 1'b0;
    load_pkt(c, 3, 8'hA5, 0);
    model_take(c);
    wait_out_valid("bp_out_valid");
    check("bp_first", OUT_DATA, 8'hA5);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge CLK);
      check("bp_hold_data", OUT_DATA, 8'hA5);
      check("bp_hold_ready", IN_READY, 0);
    end
    tick();
    OUT_READY = 1'b1;
    #1;
    check("bp_release_ready", IN_READY, 1 << c);
    drain("bp_drain");

    // Granted source stalls after its first beat
    c = ptr_m;
    hold[c] = 1'b1;
    load_pkt(c, 3, 8'h60, 0);
`ifdef STREAM_MUX_WATCHDOG_EN
    b = pend[c].pop_front();
    e.data = b.data;
    e.last = b.last;
    e.chan = CW'(c);
    exp_q.push_back(e);
    pend[c].delete();
    wait_out_valid("wd_first");
    n = 1;
    while (!ERR_TIMEOUT && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("wd_stall_cycles", n, TIMEOUT);
    @(negedge CLK);
    check("wd_pulse_one_cycle", ERR_TIMEOUT, 0);
    check("wd_idle_no_ready", IN_READY, 0);
    tick();
    src_q[c].delete();
    mid_pkt[c] = 1'b0;
    hold[c] = 1'b0;
    ptr_m = (c + 1) % N_CH;
    for (int ch = 0; ch < N_CH; ch++) load_pkt(ch, 1, W'(8'h70 + ch), 0);
    model_rr();
    drain("wd_drain");
`else
    model_take(c);
    wait_out_valid("stall_first");
    bad = 0;
    repeat (25) begin
      @(negedge CLK);
      if (ERR_TIMEOUT) bad++;
    end
    check("stall_no_err", bad, 0);
    check("stall_still_granted", IN_READY, 1 << c);
    tick();
    hold[c] = 1'b0;
    drain("stall_drain");
`endif

    // Reset mid-packet with OUT_VALID high
    c = ptr_m;
    OUT_READY = 1'b0;
    load_pkt(c, 4, 8'h80, 0);
    wait_out_valid("rst_mid_valid");
    tick();
    #1;
    RST = 1'b1;
    #1;
    check("rst_async_valid", OUT_VALID, 0);
    check("rst_async_data", OUT_DATA, 0);
    check("rst_async_last", OUT_LAST, 0);
    check("rst_async_chan", OUT_CHAN, 0);
    check("rst_async_ready", IN_READY, 0);
    check("rst_async_err", ERR_TIMEOUT, 0);
    for (int ch = 0; ch < N_CH; ch++) begin
      src_q[ch].delete();
      pend[ch].delete();
    end
    mid_pkt = '0;
    hold = '0;
    exp_q.delete();
    ptr_m = 0;
    tick();
    tick();
    RST = 1'b0;
    rdy_rand = 1;
    for (int ch = N_CH - 1; ch >= 0; ch--) load_pkt(ch, 2, '0, 1);
    model_rr();
    drain("post_rst_drain");
    gap_en = 1;
    for (int ch = 0; ch < N_CH; ch++) load_pkt(ch, $urandom_range(1, 4), '0, 1);
    model_rr();
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

endmodule
